// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game/timer counter path.
//   game_state_t : run/pause control FSM states (IDLE, RUN, PAUSE)
//   GAME_WIDTH   : default count register width
//   GAME_MOD10   : default modulus (one decimal digit)
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } game_state_t;

    localparam int GAME_WIDTH = 4;
    localparam int GAME_MOD10 = 10;

endpackage

// File: rtl/btn_edge_det.sv
// ---------------------------------------------------------------------------
// btn_edge_det
// One-register rising-edge detector for an already debounced, synchronous
// push button.
//   gameclk : clock
//   rst     : synchronous active-low reset (clears the history register)
//   btn     : button level
//   rise    : high on the first cycle btn is seen high after being low
//   btn_q   : btn delayed by one gameclk cycle
// ---------------------------------------------------------------------------
module btn_edge_det (
    input  logic gameclk,
    input  logic rst,
    input  logic btn,
    output logic rise,
    output logic btn_q
);

    always_ff @(posedge gameclk) begin
        if (!rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    // A held button keeps btn_q high, so only one rise per press.
    assign rise = btn & ~btn_q;

endmodule

// File: rtl/game_counter_mod.sv
// ---------------------------------------------------------------------------
// game_counter_mod
// Modulo-MODULUS up/down counter gated by a run/pause/idle FSM toggled by a
// push button. Instances cascade by feeding carry_out into the next en.
//   gameclk   : clock
//   rst       : synchronous active-low reset
//   btn       : run/pause button level (debounced, synchronous)
//   en        : count tick qualifier
//   up_dn     : 1 = count up, 0 = count down
//   load      : synchronous load strobe (value clamped to MODULUS-1)
//   load_val  : value for load
//   clr       : synchronous clear to START, FSM back to IDLE
//   count_out : current count
//   carry_out : one-cycle pulse on wrap in either direction
//   running   : registered "FSM is in RUN" flag
// ---------------------------------------------------------------------------
module game_counter_mod
    import game_pkg::*;
#(
    parameter int WIDTH   = GAME_WIDTH,
    parameter int MODULUS = GAME_MOD10,
    parameter int START   = 0
) (
    input  logic             gameclk,
    input  logic             rst,
    input  logic             btn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] count_out,
    output logic             carry_out,
    output logic             running
);

    localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] CNT_START = WIDTH'(START);

    game_state_t state;
    logic        btn_rise;
    logic        btn_q_unused;   // only the edge matters to the FSM

    btn_edge_det u_btn_edge (
        .gameclk (gameclk),
        .rst     (rst),
        .btn     (btn),
        .rise    (btn_rise),
        .btn_q   (btn_q_unused)
    );

    // Next count and wrap flag as {carry, count}. Encodings above CNT_MAX
    // are unreachable; if present they recover to the wrap target without
    // signalling a carry.
    function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] cur,
                                            input logic             up);
        if (up) begin
            if (cur == CNT_MAX) return {1'b1, {WIDTH{1'b0}}};
            if (cur > CNT_MAX)  return {1'b0, {WIDTH{1'b0}}};
            return {1'b0, cur + 1'b1};
        end
        if (cur == '0)      return {1'b1, CNT_MAX};
        if (cur > CNT_MAX)  return {1'b0, CNT_MAX};
        return {1'b0, cur - 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    always_ff @(posedge gameclk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            count_out <= CNT_START;
            carry_out <= 1'b0;
            running   <= 1'b0;
        end else begin
            // running trails state by one cycle, giving the two-cycle
            // button-to-running latency.
            running   <= (state == ST_RUN);
            carry_out <= 1'b0;

            // clr wins over a simultaneous button edge.
            if (clr) begin
                state <= ST_IDLE;
            end else if (btn_rise) begin
                case (state)
                    ST_IDLE, ST_PAUSE: state <= ST_RUN;
                    ST_RUN:            state <= ST_PAUSE;
                    default:           state <= ST_IDLE;
                endcase
            end

            // Counting uses the registered state, so the edge that enters
            // RUN does not itself count.
            if (clr) begin
                count_out <= CNT_START;
            end else if (load) begin
                count_out <= clamp(load_val);
            end else if (state == ST_RUN && en) begin
                {carry_out, count_out} <= step(count_out, up_dn);
            end
        end
    end

endmodule

// File: tb/tb_game_counter_mod.sv
module tb_game_counter_mod;

    logic gameclk = 1'b0;
    always #5 gameclk = ~gameclk;

    logic       rst, btn, en, up_dn, load, clr;
    logic [3:0] ld_val;

    logic [3:0] cnt10;
    logic       car10, run10;
    logic [2:0] cnt6;
    logic       car6, run6;

    game_counter_mod dut10 (
        .gameclk   (gameclk),
        .rst       (rst),
        .btn       (btn),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (ld_val),
        .clr       (clr),
        .count_out (cnt10),
        .carry_out (car10),
        .running   (run10)
    );

    game_counter_mod #(.WIDTH(3), .MODULUS(6), .START(3)) dut6 (
        .gameclk   (gameclk),
        .rst       (rst),
        .btn       (btn),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (ld_val[2:0]),
        .clr       (clr),
        .count_out (cnt6),
        .carry_out (car6),
        .running   (run6)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: index 0 = mod-10 instance, index 1 = mod-6 instance.
    int mm[2] = '{10, 6};
    int ms[2] = '{0, 3};
    int mc[2] = '{0, 0};
    int mcar[2] = '{0, 0};
    int mst  = 0;   // 0 idle, 1 run, 2 pause
    int mrun = 0;
    int mbq  = 0;

    typedef struct {
        int rst;
        int btn;
        int cnt;
        int run;
        int car;
    } vec_t;

    function automatic vec_t mk(int r, int b, int c, int rn, int cr);
        vec_t v;
        v.rst = r; v.btn = b; v.cnt = c; v.run = rn; v.car = cr;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int r, input int b, input int e, input int u,
                         input int l, input int v, input int c);
        rst    = (r != 0);
        btn    = (b != 0);
        en     = (e != 0);
        up_dn  = (u != 0);
        load   = (l != 0);
        ld_val = 4'(v);
        clr    = (c != 0);
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int rise;
        int lv;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                mc[d]   = ms[d];
                mcar[d] = 0;
            end
            mst  = 0;
            mrun = 0;
            mbq  = 0;
        end else begin
            rise = (btn && mbq == 0) ? 1 : 0;
            for (int d = 0; d < 2; d++) begin
                lv      = (d == 0) ? int'(ld_val) : int'(ld_val) % 8;
                mcar[d] = 0;
                if (clr) begin
                    mc[d] = ms[d];
                end else if (load) begin
                    mc[d] = (lv > mm[d] - 1) ? mm[d] - 1 : lv;
                end else if (mst == 1 && en) begin
                    if (up_dn) begin
                        mcar[d] = (mc[d] + 1 == mm[d]) ? 1 : 0;
                        mc[d]   = (mc[d] + 1) % mm[d];
                    end else begin
                        mcar[d] = (mc[d] == 0) ? 1 : 0;
                        mc[d]   = (mc[d] + mm[d] - 1) % mm[d];
                    end
                end
            end
            mrun = (mst == 1) ? 1 : 0;
            if (clr)       mst = 0;
            else if (rise) mst = (mst == 1) ? 2 : 1;
            mbq = btn ? 1 : 0;
        end
    endtask

    task automatic tick();
        @(posedge gameclk);
        model_step();
        #1;
        chk("m_cnt10", int'(cnt10), mc[0]);
        chk("m_car10", int'(car10), mcar[0]);
        chk("m_run10", int'(run10), mrun);
        chk("m_cnt6",  int'(cnt6),  mc[1]);
        chk("m_car6",  int'(car6),  mcar[1]);
        chk("m_run6",  int'(run6),  mrun);
    endtask

    initial begin
        vec_t tbl[22];
        int   dexp[7] = '{5, 4, 3, 2, 1, 0, 5};
        int   en_pat[4] = '{1, 0, 0, 1};
        int   gexp[4] = '{3, 3, 3, 4};
        int   rises;
        int   prev_run;

        drive(0, 0, 1, 1, 0, 0, 0);

        // Reset, start, full up-count wrap, then pause at 4/5.
        tbl[0]  = mk(0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 1, 1, 0);
        for (int i = 6; i <= 13; i++) tbl[i] = mk(1, 0, i - 4, 1, 0);
        tbl[14] = mk(1, 0, 0, 1, 1);
        tbl[15] = mk(1, 0, 1, 1, 0);
        tbl[16] = mk(1, 0, 2, 1, 0);
        tbl[17] = mk(1, 0, 3, 1, 0);
        tbl[18] = mk(1, 0, 4, 1, 0);
        tbl[19] = mk(1, 1, 5, 1, 0);
        tbl[20] = mk(1, 0, 5, 0, 0);
        tbl[21] = mk(1, 0, 5, 0, 0);

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rst, tbl[i].btn, 1, 1, 0, 0, 0);
            tick();
            chk("tbl_cnt", int'(cnt10), tbl[i].cnt);
            chk("tbl_run", int'(run10), tbl[i].run);
            chk("tbl_car", int'(car10), tbl[i].car);
        end

        // Hold btn for 20 cycles: a single resume, counting from 5.
        rises    = 0;
        prev_run = int'(run10);
        drive(1, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (run10 && prev_run == 0) rises++;
            prev_run = int'(run10);
        end
        chk("hold_rises", rises, 1);
        chk("hold_cnt", int'(cnt10), 4);
        chk("hold_run", int'(run10), 1);

        // Down count on the mod-6 instance from 0.
        drive(1, 0, 1, 0, 0, 0, 1); tick();
        drive(1, 0, 1, 0, 1, 0, 0); tick();
        drive(1, 1, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("dn_cnt6", int'(cnt6), dexp[i]);
            chk("dn_car6", int'(car6), (i == 0 || i == 6) ? 1 : 0);
        end

        // Load and clamp while paused; load together with clr.
        drive(1, 1, 0, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 0, 0, 0); tick();
        drive(1, 0, 1, 1, 1, 7, 0); tick();
        chk("ld7_cnt10", int'(cnt10), 7);
        chk("ld7_cnt6", int'(cnt6), 5);
        drive(1, 0, 1, 1, 0, 0, 0); tick();
        chk("pause_hold", int'(cnt10), 7);
        chk("pause_run", int'(run10), 0);
        drive(1, 0, 1, 1, 1, 13, 0); tick();
        chk("clamp_cnt10", int'(cnt10), 9);
        chk("clamp_cnt6", int'(cnt6), 5);
        drive(1, 0, 1, 1, 1, 3, 1); tick();
        chk("ldclr_cnt10", int'(cnt10), 0);
        chk("ldclr_cnt6", int'(cnt6), 3);
        drive(1, 0, 1, 1, 0, 0, 0); tick();
        chk("idle_hold", int'(cnt10), 0);
        chk("idle_run", int'(run10), 0);

        // Enable gating from count 2.
        drive(1, 0, 0, 1, 1, 2, 0); tick();
        drive(1, 1, 0, 1, 0, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, en_pat[i], 1, 0, 0, 0);
            tick();
            chk("gate_cnt", int'(cnt10), gexp[i]);
            chk("gate_car", int'(car10), 0);
        end

        // Reset overriding btn edge, clr and load at count 8 in RUN.
        drive(1, 0, 0, 1, 1, 8, 0); tick();
        chk("pre_rst_cnt", int'(cnt10), 8);
        drive(0, 1, 1, 1, 1, 5, 1); tick();
        chk("rst_cnt10", int'(cnt10), 0);
        chk("rst_run", int'(run10), 0);
        chk("rst_car", int'(car10), 0);
        chk("rst_cnt6", int'(cnt6), 3);
        drive(1, 0, 1, 1, 0, 0, 0); tick();
        chk("post_rst_cnt", int'(cnt10), 0);
        chk("post_rst_run", int'(run10), 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) != 0) ? 1 : 0,
                  ($urandom_range(0, 3) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0) ? 1 : 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
